// File: rtl/score_controller_if.sv
// Line-clear handshake and score/status bundle between the board logic,
// the score controller and the HEX display decoder.
interface score_controller_if;
   logic        clear_valid;
   logic [2:0]  clear_count;
   logic        clear_ready;
   logic [23:0] score_bcd;
   logic [9:0]  lines_total;
   logic [3:0]  level;
   logic        bcd_valid;
   logic        busy;

   modport master (
      output clear_valid,
      output clear_count,
      input  clear_ready,
      input  score_bcd,
      input  lines_total,
      input  level,
      input  bcd_valid,
      input  busy
   );

   modport slave (
      input  clear_valid,
      input  clear_count,
      output clear_ready,
      output score_bcd,
      output lines_total,
      output level,
      output bcd_valid,
      output busy
   );
endinterface

// File: rtl/score_controller.sv
// Score controller: accumulates score, lines and level from line-clear
// events and publishes a 6-digit BCD score via iterative double-dabble.
module score_controller #(
   parameter int SCORE_W   = 20,
   parameter int MAX_SCORE = 999999,
   parameter int MAX_LINES = 999,
   parameter int MAX_LEVEL = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_reset,
   score_controller_if.slave  bus
);

   localparam int SUM_W = SCORE_W + 1;
   localparam int BCD_W = 24;
   localparam int SH_W  = BCD_W + SCORE_W;
   localparam int CNT_W = $clog2(SCORE_W);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      CONVERT,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           count_q, count_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [9:0]           lines_q, lines_d;
   logic [3:0]           level_q, level_d;
   logic [SH_W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]     bit_q, bit_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;

   logic                 legal;
   logic [10:0]          base;
   logic [4:0]           lvl_inc;
   logic [14:0]          points;
   logic [SUM_W-1:0]     score_sum;
   logic [SCORE_W-1:0]   score_sat;
   logic [10:0]          lines_sum;
   logic [9:0]           lines_sat;
   logic [9:0]           lvl_raw;
   logic [3:0]           level_new;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
   function automatic logic [SH_W-1:0] dabble_step(
      input logic [SH_W-1:0] s
   );
      logic [SH_W-1:0] r;
      r = s;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (r[SCORE_W + 4*i +: 4] >= 4'd5) begin
            r[SCORE_W + 4*i +: 4] = r[SCORE_W + 4*i +: 4] + 4'd3;
         end
      end
      return r << 1;
   endfunction

   // Base points per line count; illegal counts never reach ADD.
   always_comb begin
      legal = (bus.clear_count != 3'd0) && (bus.clear_count <= 3'd4);
      base  = 11'd0;
      unique case (count_q)
         3'd1:    base = 11'd40;
         3'd2:    base = 11'd100;
         3'd3:    base = 11'd300;
         3'd4:    base = 11'd1200;
         default: base = 11'd0;
      endcase
   end

   // Saturating score, line and level arithmetic for the ADD step.
   always_comb begin
      lvl_inc   = {1'b0, level_q} + 5'd1;
      points    = {4'd0, base} * {10'd0, lvl_inc};
      score_sum = {1'b0, score_q}
                + {{(SUM_W-15){1'b0}}, points};
      if (score_sum > SUM_W'(MAX_SCORE)) begin
         score_sat = SCORE_W'(MAX_SCORE);
      end else begin
         score_sat = score_sum[SCORE_W-1:0];
      end
      lines_sum = {1'b0, lines_q} + {8'd0, count_q};
      if (lines_sum > 11'(MAX_LINES)) begin
         lines_sat = 10'(MAX_LINES);
      end else begin
         lines_sat = lines_sum[9:0];
      end
      lvl_raw = lines_sat / 10'd10;
      if (lvl_raw > 10'(MAX_LEVEL)) begin
         level_new = 4'(MAX_LEVEL);
      end else begin
         level_new = lvl_raw[3:0];
      end
   end

   // Next-state logic for the sequencer and all datapath registers.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      score_d = score_q;
      lines_d = lines_q;
      level_d = level_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      bcd_d   = bcd_q;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.clear_valid && legal) begin
               count_d = bus.clear_count;
               state_d = ADD;
            end
         end
         ADD: begin
            score_d = score_sat;
            lines_d = lines_sat;
            level_d = level_new;
            shift_d = {{BCD_W{1'b0}}, score_sat};
            bit_d   = '0;
            state_d = CONVERT;
         end
         CONVERT: begin
            shift_d = dabble_step(shift_q);
            bit_d   = bit_q + CNT_W'(1);
            if (bit_q == CNT_W'(SCORE_W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = shift_q[SH_W-1 -: BCD_W];
            valid_d = 1'b1;
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   // State registers; either reset source clears the game, no pulse.
   always_ff @(posedge clk) begin
      if (reset || game_reset) begin
         state_q <= IDLE;
         count_q <= 3'd0;
         score_q <= '0;
         lines_q <= 10'd0;
         level_q <= 4'd0;
         shift_q <= '0;
         bit_q   <= '0;
         bcd_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         score_q <= score_d;
         lines_q <= lines_d;
         level_q <= level_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign bus.clear_ready = ready_q;
   assign bus.score_bcd   = bcd_q;
   assign bus.lines_total = lines_q;
   assign bus.level       = level_q;
   assign bus.bcd_valid   = valid_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_score_controller.sv
// Self-checking bench for score_controller: directed scenarios plus
// randomized events against a cycle-level behavioural reference model.
module tb_score_controller;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic game_reset = 1'b0;

   score_controller_if bus();

   score_controller dut (
      .clk        (clk),
      .reset      (reset),
      .game_reset (game_reset),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int pulses = 0;

   // Reference model state (plain integers).
   int m_score = 0;
   int m_lines = 0;
   int m_level = 0;
   int m_disp  = 0;
   int m_cyc   = -1;
   int m_cnt   = 0;
   bit m_valid = 1'b0;

   function automatic int base_pts(input int c);
      case (c)
         1: return 40;
         2: return 100;
         3: return 300;
         4: return 1200;
         default: return 0;
      endcase
   endfunction

   function automatic int to_bcd(input int v);
      int r;
      int x;
      r = 0;
      x = v;
      for (int i = 0; i < 6; i++) begin
         r = r | ((x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: m_cyc counts edges since acceptance; update at edge 1,
   // publish at edge 22.
   always @(posedge clk) begin
      if (reset || game_reset) begin
         m_score = 0;
         m_lines = 0;
         m_level = 0;
         m_disp  = 0;
         m_cyc   = -1;
         m_valid = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (m_cyc < 0) begin
            if (bus.clear_valid && bus.clear_count >= 1 &&
                bus.clear_count <= 4) begin
               m_cyc = 0;
               m_cnt = int'(bus.clear_count);
            end
         end else begin
            m_cyc++;
            if (m_cyc == 1) begin
               m_score = m_score + base_pts(m_cnt) * (m_level + 1);
               if (m_score > 999999) m_score = 999999;
               m_lines = m_lines + m_cnt;
               if (m_lines > 999) m_lines = 999;
               m_level = m_lines / 10;
               if (m_level > 9) m_level = 9;
            end
            if (m_cyc == 22) begin
               m_disp  = m_score;
               m_valid = 1'b1;
               m_cyc   = -1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (bus.bcd_valid === 1'b1) pulses++;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("clear_ready", int'(bus.clear_ready), int'(m_cyc < 0));
         check("busy", int'(bus.busy), int'(m_cyc >= 0));
         check("bcd_valid", int'(bus.bcd_valid), int'(m_valid));
         check("score_bcd", int'(bus.score_bcd), to_bcd(m_disp));
         check("lines_total", int'(bus.lines_total), m_lines);
         check("level", int'(bus.level), m_level);
      end
   end

   // Offer one event (starting at a negedge) and hold it until taken.
   task automatic send(input int c);
      bit r;
      bit ok;
      ok = 1'b0;
      bus.clear_valid = 1'b1;
      bus.clear_count = 3'(c);
      for (int n = 0; n < 100; n++) begin
         r = bus.clear_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: count %0d never accepted", c);
      end
      @(negedge clk);
      bus.clear_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 60; n++) begin
         if (bus.clear_ready) return;
         @(negedge clk);
      end
      errors++;
      checks++;
      $display("FAIL idle_timeout: clear_ready stuck low");
   endtask

   task automatic pulse_game_reset();
      game_reset = 1'b1;
      @(negedge clk);
      game_reset = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lo;
      int p0;
      bus.clear_valid = 1'b0;
      bus.clear_count = 3'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;

      check("rst_ready", int'(bus.clear_ready), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_bcd", int'(bus.score_bcd), 0);
      check("rst_lines", int'(bus.lines_total), 0);
      check("rst_level", int'(bus.level), 0);
      check("rst_valid", int'(bus.bcd_valid), 0);

      // First event: 22 busy cycles, then 000040 with a pulse.
      send(1);
      lo = 0;
      for (int n = 0; n < 40; n++) begin
         if (bus.clear_ready) break;
         lo++;
         @(negedge clk);
      end
      check("latency", lo, 22);
      check("first_valid", int'(bus.bcd_valid), 1);
      check("first_bcd", int'(bus.score_bcd), 32'h000040);
      check("first_lines", int'(bus.lines_total), 1);
      @(negedge clk);
      check("pulse_width", int'(bus.bcd_valid), 0);

      // Tetrises then a double.
      pulse_game_reset();
      send(4);
      wait_idle();
      check("t1_bcd", int'(bus.score_bcd), 32'h001200);
      send(4);
      wait_idle();
      check("t2_bcd", int'(bus.score_bcd), 32'h002400);
      send(4);
      wait_idle();
      check("t3_bcd", int'(bus.score_bcd), 32'h003600);
      check("t3_lines", int'(bus.lines_total), 12);
      check("t3_level", int'(bus.level), 1);
      send(2);
      wait_idle();
      check("d_bcd", int'(bus.score_bcd), 32'h003800);
      check("d_lines", int'(bus.lines_total), 14);

      // Event held while busy: taken in the pulse cycle.
      @(negedge clk);
      p0 = pulses;
      send(1);
      send(3);
      wait_idle();
      repeat (2) @(negedge clk);
      check("held_bcd", int'(bus.score_bcd), 32'h004480);
      check("held_lines", int'(bus.lines_total), 18);
      check("held_pulses", pulses - p0, 2);

      // Illegal counts are consumed silently.
      p0 = pulses;
      send(0);
      send(5);
      repeat (25) @(negedge clk);
      check("illegal_pulses", pulses - p0, 0);
      check("illegal_bcd", int'(bus.score_bcd), 32'h004480);
      check("illegal_lines", int'(bus.lines_total), 18);

      // game_reset in the 10th CONVERT cycle.
      p0 = pulses;
      send(1);
      repeat (10) @(negedge clk);
      pulse_game_reset();
      check("abort_ready", int'(bus.clear_ready), 1);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_bcd", int'(bus.score_bcd), 0);
      check("abort_lines", int'(bus.lines_total), 0);
      check("abort_level", int'(bus.level), 0);
      repeat (25) @(negedge clk);
      check("abort_pulses", pulses - p0, 0);
      send(1);
      wait_idle();
      check("after_abort_bcd", int'(bus.score_bcd), 32'h000040);

      // Saturation run.
      pulse_game_reset();
      for (int i = 0; i < 260; i++) begin
         send(4);
         wait_idle();
         if (i == 22) begin
            check("lvl9_lines", int'(bus.lines_total), 92);
            check("lvl9_level", int'(bus.level), 9);
         end
      end
      check("sat_bcd", int'(bus.score_bcd), 32'h999999);
      check("sat_lines", int'(bus.lines_total), 999);
      check("sat_level", int'(bus.level), 9);

      // Randomized events, gaps and resets.
      pulse_game_reset();
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(int'($urandom_range(0, 7)));
         if ($urandom_range(0, 14) == 0) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) game_reset = 1'b1;
            else reset = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            game_reset = 1'b0;
            reset = 1'b0;
         end
      end
      wait_idle();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
